mm: RTL and testbench

- 4x4 signed 32-bit matrix-multiply accelerator, C = A x B.
- Operands arrive on an AXI-Stream slave; results leave on an AXI-Stream master.
- Control and status use an AXI-Lite register at address 0x00 (ap_start / ap_done / ap_idle).
- Sits as a user-project compute engine behind the CPU's AXI-Lite and DMA-style streams.

---
 rtl/mm.sv | 152 +++++++++++++++
 tb/tb_mm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm.sv
// 4x4 signed matrix multiply C = A x B. B then A arrive row-major on the input stream,
// and C leaves row-major on the output stream. Control/status live in an AXI-Lite register at 0x00.
module mm #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    state_t                        state;
    logic                          ap_done, ap_idle;
    logic [4:0]                    in_cnt;
    logic [3:0]                    c_idx, out_idx;
    logic [15:0][pDATA_WIDTH-1:0]  a_mem, b_mem, c_mem;
    logic [3:0][pDATA_WIDTH-1:0]   prod;
    logic [pDATA_WIDTH-1:0]        dot;
    logic                          wr_sel, start_acc, clear_done, in_fire, out_fire;
    logic                          unused_ok;

    // Stream length alone frames the operands, so tlast and the upper write bits have no use.
    assign unused_ok  = ^{ss_tlast, wdata[pDATA_WIDTH-1:2]};

    assign wr_sel     = awready && awvalid && wvalid && (awaddr == '0);
    assign start_acc  = wr_sel && wdata[0] && ap_idle && !ap_done;
    assign clear_done = wr_sel && wdata[1];
    assign in_fire    = ss_tvalid && ss_tready;
    assign out_fire   = sm_tvalid && sm_tready;

    // Each CALC cycle produces one full C element: four products of row m of A and column n of B.
    for (genvar k = 0; k < 4; k++) begin : g_mac
        assign prod[k] = a_mem[{c_idx[3:2], 2'(k)}] * b_mem[{2'(k), c_idx[1:0]}];
    end
    assign dot = prod[0] + prod[1] + prod[2] + prod[3];

    always_ff @(posedge axis_clk) begin
        if (in_fire) begin
            if (in_cnt[4]) a_mem[in_cnt[3:0]] <= ss_tdata;
            else           b_mem[in_cnt[3:0]] <= ss_tdata;
        end
        if (state == CALC) c_mem[c_idx] <= dot;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
            in_cnt    <= '0;
            c_idx     <= '0;
            out_idx   <= '0;
            ss_tready <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tdata  <= '0;
            sm_tlast  <= 1'b0;
        end else begin
            if (clear_done) ap_done <= 1'b0;
            case (state)
                IDLE: if (start_acc) begin
                    state     <= LOAD;
                    ap_idle   <= 1'b0;
                    in_cnt    <= '0;
                    ss_tready <= 1'b1;
                end
                LOAD: if (in_fire) begin
                    in_cnt <= in_cnt + 5'd1;
                    if (in_cnt == 5'd31) begin
                        ss_tready <= 1'b0;
                        c_idx     <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    c_idx <= c_idx + 4'd1;
                    if (c_idx == 4'd15) begin
                        // c_mem[0] was written 15 cycles ago, so it can be presented now.
                        state     <= OUT;
                        out_idx   <= '0;
                        sm_tvalid <= 1'b1;
                        sm_tdata  <= c_mem[0];
                        sm_tlast  <= 1'b0;
                    end
                end
                OUT: if (out_fire) begin
                    if (out_idx == 4'd15) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        ap_done   <= 1'b1;
                        ap_idle   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_idx  <= out_idx + 4'd1;
                        sm_tdata <= c_mem[out_idx + 4'd1];
                        sm_tlast <= (out_idx == 4'd14);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write: one-cycle accept of address and data together; the register acts on that cycle.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            awready <= 1'b0;
            wready  <= 1'b0;
        end else if (awready) begin
            awready <= 1'b0;
            wready  <= 1'b0;
        end else if (awvalid && wvalid) begin
            awready <= 1'b1;
            wready  <= 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else if (rvalid) begin
            if (rready) rvalid <= 1'b0;
        end else if (arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= (araddr == '0) ? {{(pDATA_WIDTH-3){1'b0}}, ap_idle, ap_done, start_acc} : '0;
        end else if (arvalid) begin
            arready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mm.sv
// Randomized bench for mm: a scoreboard queue is filled from a plain 4x4 matrix model,
// and a monitor compares every output handshake and checks hold stability while stalled.
module tb_mm;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic          awready, wready, arready, rvalid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0, rdata;
    logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
    logic [DW-1:0] ss_tdata = '0;
    logic          sm_tvalid, sm_tlast;
    logic          sm_tready = 1'b1;
    logic [DW-1:0] sm_tdata;

    mm #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] got[16];
    int            got_idx = 0;
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: C[m][n] = sum_k A[m][k]*B[k][n] with 32-bit wrapping int arithmetic.
    task automatic push_expected(input int v[32]);
        int bm[4][4];
        int am[4][4];
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            bm[i / 4][i % 4] = v[i];
            am[i / 4][i % 4] = v[16 + i];
        end
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++) begin
                int acc = 0;
                for (int k = 0; k < 4; k++) acc += am[m][k] * bm[k][n];
                e.d = acc;
                e.l = (m == 3 && n == 3);
                q.push_back(e);
            end
    endtask

    always @(posedge axis_clk) begin
        #1;
        sm_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: the handshake completes on the posedge after a negedge where valid&ready are seen.
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;
    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && sm_tvalid) begin
                check("hold_data", sm_tdata, held_d);
                check("hold_last", {31'b0, sm_tlast}, {31'b0, held_l});
            end
            if (sm_tvalid && sm_tready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 32'(sm_tvalid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", sm_tdata, e.d);
                    check("out_last", {31'b0, sm_tlast}, {31'b0, e.l});
                    got[got_idx] = sm_tdata;
                    got_idx = (got_idx + 1) % 16;
                end
            end
            held_v = sm_tvalid && !sm_tready;
            held_d = sm_tdata;
            held_l = sm_tlast;
        end
    end

    task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge axis_clk);
            ok = awready;
        end
        if (!ok) check("awready_timeout", 32'd0, 32'd1);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bit ok = 1'b0;
        d = '0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge axis_clk);
            ok = arready;
        end
        if (!ok) check("arready_timeout", 32'd0, 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge axis_clk);
            ok = rvalid;
            d = rdata;
        end
        if (!ok) check("rvalid_timeout", 32'd0, 32'd1);
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic stream(input int v[32], input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) begin
            bit ok = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                ss_tvalid = 1'b0;
                @(posedge axis_clk); #1;
            end
            ss_tvalid = 1'b1; ss_tdata = v[i]; ss_tlast = (i == 31);
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge axis_clk);
                ok = ss_tready;
            end
            if (!ok) check("ss_tready_timeout", 32'd0, 32'd1);
            @(posedge axis_clk); #1;
        end
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            @(posedge axis_clk);
            t++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        repeat (2) @(posedge axis_clk);
        #1;
    endtask

    task automatic rand_run(input bit gaps);
        int v[32];
        logic [DW-1:0] r;
        for (int i = 0; i < 32; i++) v[i] = int'($urandom);
        axil_write(0, 32'h2);
        axil_write(0, 32'h1);
        push_expected(v);
        stream(v, 0, 32, gaps);
        wait_drain();
        axil_read(0, r);
        check("rand_status", r, 32'h6);
    endtask

    initial begin
        int v[32];
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) begin
            v[i] = i + 1;
            v[16 + i] = i + 2;
        end

        repeat (3) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check("rst_ss_tready", 32'(ss_tready), 32'd0);
        check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
        check("rst_sm_tdata", sm_tdata, 32'd0);
        check("rst_sm_tlast", 32'(sm_tlast), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
        @(posedge axis_clk); #1;
        axil_read(0, r);
        check("rst_status", r, 32'h4);

        // Directed run with the known product.
        axil_write(0, 32'h1);
        push_expected(v);
        stream(v, 0, 16, 1'b0);
        axil_read(0, r);
        check("mid_status", r, 32'h0);
        stream(v, 16, 32, 1'b0);
        wait_drain();
        check("c00", got[0], 32'd118);
        check("c01", got[1], 32'd132);
        check("c03", got[3], 32'd160);
        check("c33", got[15], 32'd640);
        axil_read(0, r);
        check("done_status", r, 32'h6);

        // Extra beat and held start writes after completion must be ignored.
        ss_tvalid = 1'b1; ss_tdata = 32'd99; ss_tlast = 1'b1;
        awaddr = '0; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
        repeat (8) begin
            @(negedge axis_clk);
            check("extra_beat_tready", 32'(ss_tready), 32'd0);
        end
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; ss_tvalid = 1'b0; ss_tlast = 1'b0;
        axil_read(0, r);
        check("held_start_status", r, 32'h6);

        axil_write(0, 32'h2);
        axil_read(0, r);
        check("cleared_status", r, 32'h4);

        // Same data again under random backpressure.
        rand_ready = 1'b1;
        axil_write(0, 32'h1);
        push_expected(v);
        stream(v, 0, 32, 1'b1);
        wait_drain();
        axil_read(0, r);
        check("rerun_status", r, 32'h6);

        rand_run(1'b1);
        rand_run(1'b0);

        // Reset in the middle of loading.
        axil_write(0, 32'h2);
        axil_write(0, 32'h1);
        stream(v, 0, 10, 1'b0);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        check("midrst_ss_tready", 32'(ss_tready), 32'd0);
        check("midrst_sm_tvalid", 32'(sm_tvalid), 32'd0);
        repeat (2) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        axil_read(0, r);
        check("midrst_status", r, 32'h4);

        rand_run(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
